// File: rtl/pico_ctrl.sv
// picoMips control stage: program counter, instruction decode, branch
// resolution on ACC and push-button wait/halt sequencing.
module pico_ctrl #(
    parameter int PC_WIDTH    = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic [15:0]         Instr,
    input  logic [7:0]          ACC,
    input  logic                Btn,
    output logic [PC_WIDTH-1:0] PC,
    output logic [7:0]          Imm,
    output logic [2:0]          RegAddr,
    output logic                RegWE,
    output logic                WE,
    output logic                SelSW,
    output logic                SelImm,
    output logic                UseMul,
    output logic                UseACC,
    output logic                Halted
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [3:0] OP_LDI   = 4'h1;
    localparam logic [3:0] OP_LDR   = 4'h2;
    localparam logic [3:0] OP_ADDI  = 4'h3;
    localparam logic [3:0] OP_ADDR  = 4'h4;
    localparam logic [3:0] OP_MULI  = 4'h5;
    localparam logic [3:0] OP_LDSW  = 4'h6;
    localparam logic [3:0] OP_STR   = 4'h7;
    localparam logic [3:0] OP_BZ    = 4'h8;
    localparam logic [3:0] OP_BNZ   = 4'h9;
    localparam logic [3:0] OP_BN    = 4'hA;
    localparam logic [3:0] OP_JMP   = 4'hB;
    localparam logic [3:0] OP_WAITH = 4'hC;
    localparam logic [3:0] OP_WAITL = 4'hD;
    localparam logic [3:0] OP_HALT  = 4'hE;

    logic [PC_WIDTH-1:0]    pc_reg, pc_next, pc_inc;
    logic [1:0]             state_reg, state_next;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   btn_s;
    logic [3:0]             opcode;
    logic                   running;
    logic                   we_dec, regwe_dec;
    logic                   branch_taken, is_wait, wait_ok;
    logic                   unused_instr_bit;

    // Button synchroniser: stage 0 captures the raw asynchronous input.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge Clock or negedge nReset) begin
                    if (!nReset) sync_reg[gi] <= 1'b0;
                    else         sync_reg[gi] <= Btn;
                end
            end else begin : g_rest
                always_ff @(posedge Clock or negedge nReset) begin
                    if (!nReset) sync_reg[gi] <= 1'b0;
                    else         sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign btn_s            = sync_reg[SYNC_STAGES-1];
    assign opcode           = Instr[15:12];
    assign Imm              = Instr[7:0];
    assign RegAddr          = Instr[10:8];
    assign unused_instr_bit = Instr[11];
    assign running          = nReset && (state_reg == ST_RUN);

    always_comb begin
        we_dec    = 1'b0;
        regwe_dec = 1'b0;
        SelSW     = 1'b0;
        SelImm    = 1'b0;
        UseMul    = 1'b0;
        UseACC    = 1'b0;
        case (opcode)
            OP_LDI:  begin we_dec = 1'b1; SelImm = 1'b1; end
            OP_LDR:  we_dec = 1'b1;
            OP_ADDI: begin we_dec = 1'b1; SelImm = 1'b1; UseACC = 1'b1; end
            OP_ADDR: begin we_dec = 1'b1; UseACC = 1'b1; end
            OP_MULI: begin we_dec = 1'b1; SelImm = 1'b1; UseACC = 1'b1; UseMul = 1'b1; end
            OP_LDSW: begin we_dec = 1'b1; SelSW = 1'b1; end
            OP_STR:  regwe_dec = 1'b1;
            default: ;
        endcase
    end

    // Enables are gated by reset too, so nothing writes while nReset is low.
    assign WE     = we_dec & running;
    assign RegWE  = regwe_dec & running;
    assign Halted = (state_reg == ST_HALT);
    assign PC     = pc_reg;

    always_comb begin
        case (opcode)
            OP_BZ:   branch_taken = (ACC == 8'd0);
            OP_BNZ:  branch_taken = (ACC != 8'd0);
            OP_BN:   branch_taken = ACC[7];
            OP_JMP:  branch_taken = 1'b1;
            default: branch_taken = 1'b0;
        endcase
    end

    assign is_wait = (opcode == OP_WAITH) || (opcode == OP_WAITL);
    assign wait_ok = (opcode == OP_WAITH) ? btn_s : !btn_s;
    assign pc_inc  = pc_reg + 1'b1;

    always_comb begin
        pc_next    = pc_reg;
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (branch_taken)
                    pc_next = Instr[PC_WIDTH-1:0];
                else if (is_wait && !wait_ok)
                    state_next = ST_WAIT;
                else if (opcode == OP_HALT)
                    state_next = ST_HALT;
                else
                    pc_next = pc_inc;
            end
            ST_WAIT: begin
                if (is_wait && wait_ok) begin
                    pc_next    = pc_inc;
                    state_next = ST_RUN;
                end
            end
            ST_HALT: ;
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            pc_reg    <= '0;
            state_reg <= ST_RUN;
        end else begin
            pc_reg    <= pc_next;
            state_reg <= state_next;
        end
    end

endmodule
